// File: rtl/inst_fetch_queue_pkg.sv
// rtl/inst_fetch_queue_pkg.sv - shared widths and defaults for the instruction fetch queue
package inst_fetch_queue_pkg;
  localparam int              WORD          = 32;
  localparam logic [WORD-1:0] PC_RST        = 32'h1C00_0000;
  localparam int              IFQ_DEPTH     = 4;
  localparam int              IFQ_MAX_OUTST = 2;
endpackage

// File: rtl/inst_fetch_queue_if.sv
// rtl/inst_fetch_queue_if.sv - SRAM request/response and decode handshake bundle
interface inst_fetch_queue_if import inst_fetch_queue_pkg::*; #(
  parameter int W = WORD
);
  logic         inst_req;
  logic [W-1:0] inst_addr;
  logic         inst_addr_ok;
  logic         inst_data_ok;
  logic [W-1:0] inst_rdata;
  logic         if_valid;
  logic [W-1:0] if_pc;
  logic [W-1:0] if_inst;
  logic         id_ready;

  // master: the fetch queue; slave: SRAM port and decode stage
  modport master (
    output inst_req, inst_addr, if_valid, if_pc, if_inst,
    input  inst_addr_ok, inst_data_ok, inst_rdata, id_ready
  );
  modport slave (
    input  inst_req, inst_addr, if_valid, if_pc, if_inst,
    output inst_addr_ok, inst_data_ok, inst_rdata, id_ready
  );
endinterface

// File: rtl/inst_fetch_queue_fifo.sv
// rtl/inst_fetch_queue_fifo.sv - generic synchronous FIFO (ifq_fifo) with clear, count, full/empty
module ifq_fifo import inst_fetch_queue_pkg::*; #(
  parameter  int WIDTH = 2 * WORD,
  parameter  int DEPTH = IFQ_DEPTH,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer bit separates full from empty when the index bits match
  assign empty     = (r_wptr == r_rptr);
  assign full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign count     = r_wptr - r_rptr;
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  // Head is masked while empty so it reads zero out of reset and after a flush
  assign head      = empty ? '0 : r_mem[r_rptr[AW-1:0]];

  // Pointer update; clear and reset both empty the queue
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset because head is masked when empty
  always_ff @(posedge clk) begin
    if (rst && !clear && w_do_push) r_mem[r_wptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - fetch request issue, PC tagging and instruction buffer (optional IF_PERF_CNT_EN counters)
module inst_fetch_queue import inst_fetch_queue_pkg::*; #(
  parameter int DEPTH     = IFQ_DEPTH,
  parameter int MAX_OUTST = IFQ_MAX_OUTST
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD-1:0]   pc_in,
  output logic              pc_stall,
  input  logic              redirect,
  inst_fetch_queue_if.master bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_flush_drops
`endif
);
  localparam int DAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TAW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [TAW:0] T_ONE = {{TAW{1'b0}}, 1'b1};

  logic [2*WORD-1:0] w_fifo_head;
  logic [DAW:0]      w_fifo_cnt;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [WORD-1:0]   w_tag_head;
  logic [TAW:0]      w_outst;
  logic              w_tag_full;
  logic              w_tag_empty;
  logic [TAW:0]      r_discard;
  logic              w_credit_ok;
  logic              w_issue;
  logic              w_fire;
  logic              w_drop;
  logic              w_push;
  logic              w_pop;

  // Outstanding requests reserve FIFO space so a returning response always fits
  assign w_credit_ok   = (int'(w_fifo_cnt) + int'(w_outst)) < DEPTH;
  assign w_issue       = rst && !redirect && w_credit_ok && !w_tag_full;
  assign w_fire        = w_issue && bus.inst_addr_ok;
  assign pc_stall      = !w_fire;
  assign bus.inst_req  = w_issue;
  assign bus.inst_addr = pc_in;

  // Responses owed to a flushed path are dropped, as is one arriving with the redirect
  assign w_drop = bus.inst_data_ok && (redirect || (r_discard != '0));
  assign w_push = bus.inst_data_ok && !w_drop;
  assign w_pop  = bus.if_valid && bus.id_ready && !redirect;

  assign bus.if_valid = !w_fifo_empty;
  assign bus.if_pc    = w_fifo_head[2*WORD-1:WORD];
  assign bus.if_inst  = w_fifo_head[WORD-1:0];

  ifq_fifo #(.WIDTH(2 * WORD), .DEPTH(DEPTH)) u_inst_fifo (
    .clk(clk), .rst(rst),
    .push(w_push), .push_data({w_tag_head, bus.inst_rdata}),
    .pop(w_pop), .clear(redirect),
    .head(w_fifo_head), .count(w_fifo_cnt), .full(w_fifo_full), .empty(w_fifo_empty)
  );

  // Tag queue is never cleared: after a redirect it holds exactly the responses to discard
  ifq_fifo #(.WIDTH(WORD), .DEPTH(MAX_OUTST)) u_tag_fifo (
    .clk(clk), .rst(rst),
    .push(w_fire), .push_data(pc_in),
    .pop(bus.inst_data_ok), .clear(1'b0),
    .head(w_tag_head), .count(w_outst), .full(w_tag_full), .empty(w_tag_empty)
  );

  // Discard counter: loaded from the responses still owed on redirect, drained as they return
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_discard <= '0;
    end else if (redirect) begin
      r_discard <= (bus.inst_data_ok && (w_outst != '0)) ? (w_outst - T_ONE) : w_outst;
    end else if (bus.inst_data_ok && (r_discard != '0)) begin
      r_discard <= r_discard - T_ONE;
    end
  end

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(w_push && w_fifo_full && !w_pop));
  a_tag_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(w_fire && w_tag_full && !bus.inst_data_ok));
  a_tag_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    !(bus.inst_data_ok && w_tag_empty));

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_drops;

  // Saturating stall-cycle count and count of work thrown away by redirects
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_stall <= '0;
      r_perf_drops <= '0;
    end else begin
      if (pc_stall && (r_perf_stall != 32'hFFFF_FFFF)) r_perf_stall <= r_perf_stall + 32'd1;
      r_perf_drops <= r_perf_drops + 32'(w_drop) + (redirect ? 32'(w_fifo_cnt) : 32'd0);
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_flush_drops  = r_perf_drops;
`endif
endmodule
